// File: rtl/button_command_encoder.sv
// Seven push-buttons -> one-cycle 3-bit command pulses with forced idle gaps.
// Optional auto-repeat of held buttons: define BUTTON_COMMAND_ENCODER_AUTO_REPEAT_EN.
module button_command_encoder #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int GAP_CYCLES      = 1,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] btn,
    input  logic       clear_ovf,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    output logic [6:0] btn_level,
    output logic       ovf
);
    localparam int NB = 7;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    if (DEBOUNCE_CYCLES < 1 || GAP_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("button_command_encoder: all cycle parameters must be >= 1");
    end

    logic [NB-1:0]         sync1, sync2;
    logic [NB-1:0][DW-1:0] db_cnt;
    logic [NB-1:0]         db_hit, press_evt, rpt_set, pending, issue_clr;
    logic [2:0]            issue_code;
    logic                  issue_go;
    state_t                state;
    logic [GW-1:0]         gap_cnt;

    // db_hit marks the edge on which the debounced level flips
    always_comb begin
        db_hit    = '0;
        press_evt = '0;
        for (int i = 0; i < NB; i++) begin
            db_hit[i]    = (sync2[i] != btn_level[i]) && (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1));
            press_evt[i] = db_hit[i] && !btn_level[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            db_cnt    <= '0;
            btn_level <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == btn_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_hit[i]) begin
                    db_cnt[i]    <= '0;
                    btn_level[i] <= ~btn_level[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef BUTTON_COMMAND_ENCODER_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [NB-1:0][RW-1:0] rpt_cnt;
    logic [NB-1:0]         rpt_phase;

    // rpt_phase=0 waits for the initial delay, 1 for the steady period
    always_comb begin
        rpt_set = '0;
        for (int i = 0; i < NB; i++)
            rpt_set[i] = btn_level[i] &&
                (rpt_cnt[i] == (rpt_phase[i] ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_cnt   <= '0;
            rpt_phase <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (!btn_level[i]) begin
                    rpt_cnt[i]   <= '0;
                    rpt_phase[i] <= 1'b0;
                end else if (rpt_set[i]) begin
                    rpt_cnt[i]   <= '0;
                    rpt_phase[i] <= 1'b1;
                end else begin
                    rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign rpt_set = '0;
`endif

    // lowest pending index wins: scan downward so the last hit is the lowest
    always_comb begin
        issue_clr  = '0;
        issue_code = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (pending[i]) begin
                issue_clr  = NB'(1) << i;
                issue_code = 3'(i + 1);
            end
        end
    end

    assign issue_go = (state == IDLE) && (|pending);

    // sets are ORed after the clear so a same-cycle set survives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            ovf     <= 1'b0;
        end else begin
            pending <= (pending & ~(issue_go ? issue_clr : '0)) | press_evt | rpt_set;
            if (|(press_evt & pending))
                ovf <= 1'b1;
            else if (clear_ovf)
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            cmd       <= '0;
            cmd_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (issue_go) begin
                    cmd       <= issue_code;
                    cmd_valid <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    cmd       <= '0;
                    cmd_valid <= 1'b0;
                    gap_cnt   <= GW'(GAP_CYCLES - 1);
                    state     <= GAP;
                end
                GAP: begin
                    if (gap_cnt == '0) state <= IDLE;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
